// File: rtl/jtgng_vtimer.sv
// jtgng_vtimer: cen6-paced video timer; in clk/rst_n/cen6, out H/V counters, Hinit/Vinit, LHBL/LVBL, HS/VS, frame
module jtgng_vtimer #(
  parameter int unsigned HTOTAL   = 384,
  parameter int unsigned HB_START = 256,
  parameter int unsigned HS_START = 296,
  parameter int unsigned HS_END   = 328,
  parameter int unsigned VTOTAL   = 262,
  parameter int unsigned VB_START = 240,
  parameter int unsigned VB_END   = 16,
  parameter int unsigned VS_START = 248,
  parameter int unsigned VS_END   = 251
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen6,
  output logic [8:0] H,
  output logic [8:0] V,
  output logic       Hinit,
  output logic       Vinit,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS,
  output logic       frame
);
  logic [8:0] hn, vn;
  logic hw, vw, hi;
  always_comb begin
    hw = H == 9'(HTOTAL - 1);
    vw = V == 9'(VTOTAL - 1);
    hn = hw ? 9'd0 : H + 9'd1;
    vn = !hw ? V : vw ? 9'd0 : V + 9'd1;
    hi = 32'(hn) == HTOTAL - 1;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      H     <= 9'd0;
      V     <= 9'd0;
      Hinit <= 1'b0;
      Vinit <= 1'b0;
      LHBL  <= 1'b1;
      LVBL  <= 1'b0;
      HS    <= 1'b0;
      VS    <= 1'b0;
      frame <= 1'b0;
    end else if (cen6) begin
      H     <= hn;
      V     <= vn;
      Hinit <= hi;
      Vinit <= hi && 32'(vn) == VTOTAL - 1;
      LHBL  <= 32'(hn) < HB_START;
      LVBL  <= 32'(vn) >= VB_END && 32'(vn) < VB_START;
      HS    <= 32'(hn) >= HS_START && 32'(hn) < HS_END;
      VS    <= 32'(vn) >= VS_START && 32'(vn) < VS_END;
      frame <= frame ^ (hw & vw);
    end
endmodule

// File: tb/tb_jtgng_vtimer.sv
// tb_jtgng_vtimer: directed checks of default, overridden and reduced-size video timers against a pulse-count model
module tb_jtgng_vtimer;
  logic clk = 1'b0, rst_n = 1'b0, cen6 = 1'b0;
  logic [8:0] hd, vd, ho, vo, hs9, vs9;
  logic hid, vid, lhd, lvd, hsd, vsd, fd;
  logic hio, vio, lho, lvo, hso, vso, fo;
  logic his, vis, lhs, lvs, hss, vss, fs;
  logic [24:0] got_d, got_o, got_s;
  int n = 0, cmp = 0, bad = 0;

  always #5 clk = ~clk;

  jtgng_vtimer dut (.clk(clk), .rst_n(rst_n), .cen6(cen6), .H(hd), .V(vd), .Hinit(hid), .Vinit(vid),
    .LHBL(lhd), .LVBL(lvd), .HS(hsd), .VS(vsd), .frame(fd));
  jtgng_vtimer #(.HTOTAL(320), .VTOTAL(256), .VB_START(224)) dut_o (.clk(clk), .rst_n(rst_n), .cen6(cen6),
    .H(ho), .V(vo), .Hinit(hio), .Vinit(vio), .LHBL(lho), .LVBL(lvo), .HS(hso), .VS(vso), .frame(fo));
  jtgng_vtimer #(.HTOTAL(20), .HB_START(16), .HS_START(17), .HS_END(19), .VTOTAL(12), .VB_START(9),
    .VB_END(2), .VS_START(10), .VS_END(11)) dut_s (.clk(clk), .rst_n(rst_n), .cen6(cen6),
    .H(hs9), .V(vs9), .Hinit(his), .Vinit(vis), .LHBL(lhs), .LVBL(lvs), .HS(hss), .VS(vss), .frame(fs));

  assign got_d = {hd, vd, hid, vid, lhd, lvd, hsd, vsd, fd};
  assign got_o = {ho, vo, hio, vio, lho, lvo, hso, vso, fo};
  assign got_s = {hs9, vs9, his, vis, lhs, lvs, hss, vss, fs};

  function automatic logic [24:0] model(int k, int ht, int hb, int hs0, int hs1, int vt, int vb0, int vb1,
                                        int vs0, int vs1);
    int h, v;
    logic hi;
    h = k % ht;
    v = (k / ht) % vt;
    hi = h == ht - 1;
    return {9'(h), 9'(v), hi, hi && v == vt - 1, h < hb, v >= vb1 && v < vb0, h >= hs0 && h < hs1,
            v >= vs0 && v < vs1, 1'((k / (ht * vt)) % 2)};
  endfunction

  function automatic logic [24:0] md(int k);
    return model(k, 384, 256, 296, 328, 262, 240, 16, 248, 251);
  endfunction

  function automatic logic [24:0] mo(int k);
    return model(k, 320, 256, 296, 328, 256, 224, 16, 248, 251);
  endfunction

  function automatic logic [24:0] ms(int k);
    return model(k, 20, 16, 17, 19, 12, 9, 2, 10, 11);
  endfunction

  task automatic step(input logic c, input logic r);
    rst_n = r;
    cen6 = c;
    @(posedge clk);
    #1;
    n = r ? n + int'(c) : 0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 10; i++) step(1'(i), 1'b0);
    cmp += 3;
    if (got_d !== md(0)) begin bad++; $display("FAIL reset_def got=%h exp=%h", got_d, md(0)); end
    if (got_o !== mo(0)) begin bad++; $display("FAIL reset_ovr got=%h exp=%h", got_o, mo(0)); end
    if (got_s !== ms(0)) begin bad++; $display("FAIL reset_small got=%h exp=%h", got_s, ms(0)); end
    while (n < 50 * 384 + 100) step(1'b1, 1'b1);
    cmp++;
    if (got_d !== md(n)) begin bad++; $display("FAIL pre_midreset got=%h exp=%h", got_d, md(n)); end
    step(1'b1, 1'b0);
    cmp++;
    if (got_d !== md(0)) begin bad++; $display("FAIL midreset got=%h exp=%h", got_d, md(0)); end
  endtask

  task automatic test_line;
    step(1'b0, 1'b0);
    for (int i = 0; i < 1600; i++) begin
      step(1'(i % 2), 1'b1);
      cmp++;
      if (got_d !== md(n)) begin bad++; $display("FAIL line n=%0d got=%h exp=%h", n, got_d, md(n)); end
    end
  endtask

  task automatic test_frame;
    int tog = 0;
    logic pf;
    step(1'b0, 1'b0);
    pf = fs;
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b1);
      cmp++;
      if (got_s !== ms(n)) begin bad++; $display("FAIL frame n=%0d got=%h exp=%h", n, got_s, ms(n)); end
      if (fs !== pf) tog++;
      pf = fs;
    end
    cmp++;
    if (tog != 1) begin bad++; $display("FAIL frame_toggles got=%0d exp=1", tog); end
  endtask

  task automatic test_gating;
    int mode, len;
    logic c;
    step(1'b0, 1'b0);
    for (int s = 0; s < 150; s++) begin
      mode = $urandom_range(0, 2);
      len = mode == 0 ? 20 : $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        c = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
        step(c, 1'b1);
        cmp += 2;
        if (got_d !== md(n)) begin bad++; $display("FAIL gate_def n=%0d got=%h exp=%h", n, got_d, md(n)); end
        if (got_s !== ms(n)) begin bad++; $display("FAIL gate_small n=%0d got=%h exp=%h", n, got_s, ms(n)); end
      end
    end
  endtask

  task automatic test_simultaneous;
    step(1'b0, 1'b0);
    while (n < 239) step(1'b1, 1'b1);
    cmp++;
    if (got_s !== ms(239)) begin bad++; $display("FAIL pre_wrap got=%h exp=%h", got_s, ms(239)); end
    step(1'b1, 1'b0);
    cmp += 2;
    if (got_s !== ms(0)) begin bad++; $display("FAIL rst_at_wrap got=%h exp=%h", got_s, ms(0)); end
    if (fs !== 1'b0) begin bad++; $display("FAIL rst_at_wrap_frame got=%b exp=0", fs); end
  endtask

  task automatic test_override;
    step(1'b0, 1'b0);
    for (int i = 0; i < 700; i++) begin
      step(1'b1, 1'b1);
      cmp++;
      if (got_o !== mo(n)) begin bad++; $display("FAIL override n=%0d got=%h exp=%h", n, got_o, mo(n)); end
    end
  endtask

  initial begin
    test_reset;
    test_line;
    test_frame;
    test_gating;
    test_simultaneous;
    test_override;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
